// File: rtl/fifo_uart_tx.sv
// Reader side of the TX FIFO: pops one word at a time from a first-word-fall-through FIFO and
// shifts it out as a start / data (LSB first) / stop UART frame timed by an oversampled baud tick.
module fifo_uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_TICKS = 16
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_tick,
   input  logic                 i_fifo_empty,
   input  logic [DATA_BITS-1:0] i_fifo_data,
   output logic                 o_fifo_rd,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int TICK_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
   localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_q, state_d;
   logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic [DATA_BITS-1:0]   shreg_nxt;
   logic                   tx_q, tx_d;
   logic                   done_q, done_d;

   // o_tx is computed one edge ahead so the line level changes together with the state.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      tx_d       = tx_q;
      done_d     = 1'b0;
      o_fifo_rd  = 1'b0;
      shreg_nxt  = shreg_q >> 1;

      case (state_q)
         IDLE: begin
            if (!i_fifo_empty && !i_reset) begin
               o_fifo_rd  = 1'b1;
               shreg_d    = i_fifo_data;
               tick_cnt_d = '0;
               state_d    = START;
               tx_d       = 1'b0;
            end
         end
         START: begin
            if (i_tick) begin
               if (tick_cnt_q == OS_LAST) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = DATA;
                  tx_d       = shreg_q[0];
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (i_tick) begin
               if (tick_cnt_q == OS_LAST) begin
                  shreg_d    = shreg_nxt;
                  tick_cnt_d = '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                     tx_d      = shreg_nxt[0];
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (i_tick) begin
               if (tick_cnt_q == STOP_LAST) begin
                  state_d    = IDLE;
                  tick_cnt_d = '0;
                  done_d     = 1'b1;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   assign o_tx   = tx_q;
   assign o_busy = (state_q != IDLE);
   assign o_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a small FIFO model and tick generator drive the default
// instance; a second instance with two stop bits covers the long stop period.
module tb_fifo_uart_tx;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, tick, empty;
   logic [7:0] data;
   logic       rd, tx, busy, done;

   logic       rst2, tick2, empty2;
   logic [7:0] data2;
   logic       rd2, tx2, busy2, done2;

   logic [7:0] mem [0:7];
   logic [7:0] rp = 8'd0;
   logic [7:0] wp = 8'd0;
   int         tdiv = 4;
   int         tcnt = 0;
   int         pops = 0;
   int         checks = 0;
   int         errors = 0;
   int         n, nb, k, brd, btx, bb, run;

   assign empty = (rp == wp);
   assign data  = mem[rp[2:0]];
   assign tick  = (tcnt == 0);

   always @(posedge clk) begin
      if (rd) begin
         rp   <= rp + 8'd1;
         pops <= pops + 1;
      end
      tcnt <= (tcnt + 1 >= tdiv) ? 0 : tcnt + 1;
   end

   fifo_uart_tx dut (
      .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_fifo_empty(empty), .i_fifo_data(data),
      .o_fifo_rd(rd), .o_tx(tx), .o_busy(busy), .o_done(done)
   );

   fifo_uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_TICKS(32)) dut2 (
      .i_clock(clk), .i_reset(rst2), .i_tick(tick2), .i_fifo_empty(empty2), .i_fifo_data(data2),
      .o_fifo_rd(rd2), .o_tx(tx2), .o_busy(busy2), .o_done(done2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wp[2:0]] = d;
      wp = wp + 8'd1;
   endtask

   // Call at the first negedge after the pop edge; checks each level mid-bit, then the done pulse.
   task automatic frame1(input logic [7:0] d);
      logic [9:0] fr;
      int consumed, guard, early;
      logic t;
      fr = {1'b1, d, 1'b0};
      consumed = 0; guard = 0; early = 0;
      while (consumed < 160 && guard < 5000) begin
         t = tick;
         @(negedge clk);
         guard++;
         if (t) begin
            consumed++;
            if (consumed % 16 == 8)
               chk($sformatf("bit%0d_of_%0h", consumed / 16, d), 32'(tx), 32'(fr[consumed / 16]));
         end
         if (done && consumed < 160) early++;
      end
      chk("frame_ticks", 32'(consumed), 32'd160);
      chk("done_early", 32'(early), 32'd0);
      chk("done_pulse", 32'({busy, done}), 32'h1);
      @(negedge clk);
      chk("done_clear", 32'(done), 32'd0);
   endtask

   initial begin
      rst = 1'b1; rst2 = 1'b1; empty2 = 1'b1; data2 = 8'h00; tick2 = 1'b1;
      push(8'hA5);

      // T1: reset held with data waiting
      repeat (3) begin
         @(negedge clk);
         chk("t1_tx", 32'(tx), 32'd1);
         chk("t1_busy", 32'(busy), 32'd0);
         chk("t1_rd", 32'(rd), 32'd0);
         chk("t1_done", 32'(done), 32'd0);
      end

      // T2: single frame 0xA5, tick every 4 clocks
      tdiv = 4;
      rst = 1'b0;
      #1;
      chk("t2_pop", 32'(rd), 32'd1);
      @(negedge clk);
      chk("t2_start", 32'({tx, busy}), 32'h1);
      frame1(8'hA5);
      repeat (40) @(negedge clk);
      chk("t2_pops", 32'(pops), 32'd1);
      chk("t2_no_repop", 32'(rd), 32'd0);

      // T3: back-to-back 0x00, 0xFF with tick held high
      tdiv = 1;
      push(8'h00);
      push(8'hFF);
      #1;
      chk("t3_pop1", 32'(rd), 32'd1);
      n = 0; nb = 0;
      while (n < 400) begin
         @(negedge clk);
         n++;
         if (rd) break;
         if (busy) nb++;
      end
      chk("t3_gap", 32'(n), 32'd161);
      chk("t3_span", 32'(nb), 32'd160);
      chk("t3_idle_high", 32'({tx, busy}), 32'h2);
      @(negedge clk);
      chk("t3_start2", 32'({tx, busy}), 32'h1);
      repeat (24) @(negedge clk);
      chk("t3_ff_bit0", 32'({tx, busy}), 32'h3);
      k = 0;
      while (!done && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("t3_done2", 32'(done), 32'd1);
      chk("t3_pops", 32'(pops), 32'd3);

      // T4: empty FIFO with ticks running
      tdiv = 4;
      brd = 0; btx = 0; bb = 0;
      repeat (1000) begin
         @(negedge clk);
         if (rd !== 1'b0) brd++;
         if (tx !== 1'b1) btx++;
         if (busy !== 1'b0) bb++;
      end
      chk("t4_rd_cycles", 32'(brd), 32'd0);
      chk("t4_tx_low_cycles", 32'(btx), 32'd0);
      chk("t4_busy_cycles", 32'(bb), 32'd0);
      chk("t4_pops", 32'(pops), 32'd3);

      // T5: reset during data bit 3 of 0x3C, then a fresh 0x81 frame
      tdiv = 1;
      push(8'h3C);
      #1;
      chk("t5_pop", 32'(rd), 32'd1);
      @(negedge clk);
      repeat (69) @(negedge clk);
      chk("t5_bit3", 32'({busy, tx}), 32'h3);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_after_reset", 32'({tx, busy, done}), 32'h4);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_no_repop", 32'({rd, busy, tx}), 32'h1);
      push(8'h81);
      #1;
      chk("t5_pop2", 32'(rd), 32'd1);
      @(negedge clk);
      frame1(8'h81);
      chk("t5_pops", 32'(pops), 32'd5);

      // T6: two stop bits, tick every clock
      data2 = 8'h55;
      empty2 = 1'b0;
      rst2 = 1'b0;
      #1;
      chk("t6_pop", 32'(rd2), 32'd1);
      @(negedge clk);
      empty2 = 1'b1;
      n = 1; run = 0;
      while (!done2 && n < 400) begin
         @(negedge clk);
         n++;
         if (busy2) run = tx2 ? run + 1 : 0;
      end
      // done is set on the 176th edge after the pop edge, seen at the following negedge
      chk("t6_done_at", 32'(n), 32'd177);
      chk("t6_stop_len", 32'(run), 32'd32);
      @(negedge clk);
      chk("t6_after", 32'({done2, busy2, rd2, tx2}), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
